bin2bcd_seq: RTL
================

# bin2bcd_seq

Sequential binary-to-BCD converter using shift-add-3 (double dabble) over BIN_W clock cycles. It sits between the key-driven counter and the 8-digit 7-segment LUT stage. It takes the counter's binary value and delivers registered per-digit BCD nibbles with a start/busy/done handshake. It replaces the purely combinational converter when BIN_W grows and the adder chain no longer meets 50 MHz.

## Interface
- BIN_W, 8, width of binary input.
- DIGITS, 3, BCD digits produced; must satisfy 10^DIGITS > 2^BIN_W − 1 (elaboration-time check, fatal if violated).
- CLOCK_50  in  1  system clock; all logic on rising edge.
- rst  in  1  reset; one clock, reset is synchronous and active-high.
- start  in  1  request a conversion of binary_in (level sampled each cycle).
- binary_in  in  BIN_W  value to convert; sampled only on the accepting cycle.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse: bcd_out just updated.
- bcd_out  out  4*DIGITS  packed BCD, digit 0 (ones) in [3:0], digit 1 (tens) in [7:4], and so on.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: busy=0, done=0.
  - When start=1: load shift register {bcd_acc=0, bin_sr=binary_in}, clear iteration counter, go to SHIFT.
- SHIFT: busy=1. Each cycle does two things:
  - Adjust: every 4-bit BCD digit ≥5 gets +3. All digits are adjusted in parallel from the current value.
  - Shift: the whole {bcd_acc, bin_sr} shifts left by 1.
  - After exactly BIN_W iterations, register bcd_acc into bcd_out and go to DONE.
- DONE: done=1, busy=0.
  - If start=1 in this cycle, it is accepted exactly as in IDLE and the next state is SHIFT.
  - Otherwise the next state is IDLE.
- start in SHIFT is ignored. It is not queued.
- binary_in changes during SHIFT have no effect on the running conversion.
- bcd_out holds the last completed result until the next DONE. It never shows partial values.
- Iteration counter width is $clog2(BIN_W+1). It never wraps, because it exits at BIN_W.
- Reset (any state, including mid-SHIFT): state=IDLE, busy=0, done=0, bcd_out=0, shift register and counter cleared. An aborted conversion produces no done.

## Timing
- Start accepted in cycle n. busy=1 in cycles n+1 … n+BIN_W. In cycle n+BIN_W+1, done=1 and bcd_out holds the new value.
- Latency from start to done is BIN_W+1 cycles; with BIN_W=8 this is 9 cycles.
- Back-to-back throughput is one result per BIN_W+1 cycles: start held high, accepted in each DONE cycle.
- Outputs busy, done and bcd_out are all registered. There is no combinational path from inputs to outputs.
- Reset values: busy=0, done=0, bcd_out=0.

## Configuration
- BIN2BCD_AUTO_EN defined:
  - An internal register last_bin (reset 0) holds the most recently accepted binary_in.
  - In IDLE/DONE, an effective start = start OR (binary_in ≠ last_bin).
  - The display therefore follows the counter without external strobes.
  - After reset, the first accepted value converts if it is nonzero. A value of 0 already matches the reset bcd_out.
- BIN2BCD_AUTO_EN undefined: no last_bin register. Conversions start only on the start port.

## Structure
- Shared package bin2bcd_pkg contains:
  - FSM state enum (IDLE, SHIFT, DONE).
  - localparam BCD_ADJ_THRESH = 4'd5 and BCD_ADJ_ADD = 4'd3.
  - Function for counter width.
- One sub-module, bcd_digit_adj: combinational 4-bit in/out, +3 when ≥5.
  - Instantiated DIGITS times with a generate loop inside bin2bcd_seq.
- Downstream, bcd_out nibbles map directly onto the 7-segment LUT digit inputs.

## Test plan
- Reset, then start with binary_in=8'd0 → busy high cycles 1–8, done in cycle 9, bcd_out=12'h000.
- start with binary_in=8'd255 → done exactly 9 cycles after accept, bcd_out=12'h255. Then 8'd100 → 12'h100; 8'd37 → 12'h037.
- Accept 8'd123; assert start with binary_in=8'd45 during SHIFT → ignored, bcd_out=12'h123, single done pulse.
- Start held high with binary_in=8'd9 then 8'd10 → results 12'h009, 12'h010 on consecutive done pulses 9 cycles apart.
- Assert rst in cycle 4 of a conversion of 8'd200 → busy=0, done never pulses, bcd_out=0. Next start with 8'd200 → 12'h200.
- Under BIN2BCD_AUTO_EN, start=0 held, binary_in steps 37→38 → conversion auto-launches, bcd_out=12'h038. Input held at 38 → no further done pulses.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
// Shared types, constants and elaboration helpers for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

  function automatic int unsigned cnt_width(input int unsigned bin_w);
    return $clog2(bin_w + 1);
  endfunction

  // True when DIGITS decimal digits can hold the largest BIN_W-bit value.
  function automatic bit digits_ok(input int unsigned bin_w, input int unsigned digits);
    longint unsigned p10;
    p10 = 64'd1;
    for (int unsigned i = 0; i < digits; i++) begin
      p10 = p10 * 64'd10;
    end
    return p10 > ((64'd1 << bin_w) - 64'd1);
  endfunction

endpackage

// File: rtl/bin2bcd_if.sv
// Start/busy/done handshake plus data bus between the counter, the converter and the 7-segment LUT.
interface bin2bcd_if #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [BIN_W-1:0]      binary_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;

  modport master (output start, output binary_in, input busy, input done, input bcd_out);
  modport slave  (input start, input binary_in, output busy, output done, output bcd_out);
endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more before the shift.
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  assign o_digit = (i_digit >= BCD_ADJ_THRESH) ? (i_digit + BCD_ADJ_ADD) : i_digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter, one bit per clock, registered outputs.
// Optional BIN2BCD_AUTO_EN: auto-launch a conversion whenever binary_in differs from the last accepted value.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic            CLOCK_50,
  input  logic            rst,
  bin2bcd_if.slave        bus
);

  localparam int CNT_W = cnt_width(BIN_W);
  localparam int BCD_W = 4 * DIGITS;

  if (!digits_ok(BIN_W, DIGITS)) begin : g_digits_check
    $fatal(1, "bin2bcd_seq: DIGITS too small for BIN_W");
  end

  state_t             r_state;
  logic [BCD_W-1:0]   r_acc;
  logic [BIN_W-1:0]   r_sr;
  logic [CNT_W-1:0]   r_cnt;
  logic [BCD_W-1:0]   r_bcd_out;
  logic               r_busy;
  logic               r_done;

  logic [BCD_W-1:0]   w_adj;
  logic [BCD_W-1:0]   w_acc_next;
  logic [BIN_W-1:0]   w_sr_next;
  logic               w_start_eff;
  logic               w_unused_msb;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_digit (r_acc[4*g +: 4]),
      .o_digit (w_adj[4*g +: 4])
    );
  end

  // The adjusted top digit never exceeds 7 while DIGITS is large enough, so its MSB is always shifted out as 0.
  assign w_acc_next   = {w_adj[BCD_W-2:0], r_sr[BIN_W-1]};
  assign w_sr_next    = {r_sr[BIN_W-2:0], 1'b0};
  assign w_unused_msb = w_adj[BCD_W-1];

`ifdef BIN2BCD_AUTO_EN
  logic [BIN_W-1:0]   r_last_bin;

  assign w_start_eff = bus.start | (bus.binary_in != r_last_bin);

  // Remember the most recently accepted input so an unchanged value does not relaunch.
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      r_last_bin <= {BIN_W{1'b0}};
    end else if ((r_state != SHIFT) && w_start_eff) begin
      r_last_bin <= bus.binary_in;
    end else begin
      r_last_bin <= r_last_bin;
    end
  end
`else
  assign w_start_eff = bus.start;
`endif

  // Converter FSM: accept in IDLE/DONE, shift BIN_W times, publish the result with a one-cycle done.
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      r_state   <= IDLE;
      r_acc     <= {BCD_W{1'b0}};
      r_sr      <= {BIN_W{1'b0}};
      r_cnt     <= {CNT_W{1'b0}};
      r_bcd_out <= {BCD_W{1'b0}};
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (w_start_eff) begin
            r_acc   <= {BCD_W{1'b0}};
            r_sr    <= bus.binary_in;
            r_cnt   <= {CNT_W{1'b0}};
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        SHIFT: begin
          r_acc <= w_acc_next;
          r_sr  <= w_sr_next;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(BIN_W - 1)) begin
            r_bcd_out <= w_acc_next;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= DONE;
          end else begin
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_state   <= SHIFT;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.bcd_out = r_bcd_out;

endmodule
